// File: rtl/door_access_ctrl_if.sv
// Handshake bundle between the keypad/door hardware and the door access controller.
// The master side drives the pulses and door sensor; the slave side drives relay and status.
interface door_access_ctrl_if;
    logic       unlock_pulse;
    logic       attempt_end;
    logic       door_closed;
    logic       relay_on;
    logic       alarm;
    logic       lockout;
    logic [3:0] fail_count;

    modport master (
        output unlock_pulse,
        output attempt_end,
        output door_closed,
        input  relay_on,
        input  alarm,
        input  lockout,
        input  fail_count
    );

    modport slave (
        input  unlock_pulse,
        input  attempt_end,
        input  door_closed,
        output relay_on,
        output alarm,
        output lockout,
        output fail_count
    );
endinterface

// File: rtl/door_access_ctrl.sv
// Door strike driver with held-open alarm and failed-attempt lockout.
// One shared down-timer serves both the open window and the lockout period.
module door_access_ctrl #(
    parameter int OPEN_CYCLES    = 1000,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 5000,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                reset,
    door_access_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        LOCKED     = 3'd0,
        OPEN       = 3'd1,
        WAIT_CLOSE = 3'd2,
        LOCKOUT    = 3'd3
    } state_t;

    localparam logic [CNT_W-1:0] OPEN_RELOAD = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_RELOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);
    localparam logic [3:0]       MAX_F       = 4'(MAX_FAILS);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [3:0]       fail_count;
    logic [3:0]       fail_next;
    logic             relay_on;
    logic             alarm;
    logic             lockout;

    // Saturating increment so the counter can never wrap past MAX_FAILS.
    assign fail_next = (fail_count == MAX_F) ? fail_count : fail_count + 4'd1;

    assign bus.relay_on   = relay_on;
    assign bus.alarm      = alarm;
    assign bus.lockout    = lockout;
    assign bus.fail_count = fail_count;

    // Outputs are registered alongside every state change so they never see the inputs directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LOCKED;
            timer      <= '0;
            fail_count <= 4'd0;
            relay_on   <= 1'b0;
            alarm      <= 1'b0;
            lockout    <= 1'b0;
        end else begin
            case (state)
                LOCKED: begin
                    if (bus.unlock_pulse) begin
                        state      <= OPEN;
                        timer      <= OPEN_RELOAD;
                        fail_count <= 4'd0;
                        relay_on   <= 1'b1;
                        alarm      <= 1'b0;
                        lockout    <= 1'b0;
                    end else if (bus.attempt_end) begin
                        fail_count <= fail_next;
                        if (fail_next == MAX_F) begin
                            state   <= LOCKOUT;
                            timer   <= LOCK_RELOAD;
                            lockout <= 1'b1;
                        end
                    end
                end

                OPEN: begin
                    if (bus.unlock_pulse) begin
                        timer <= OPEN_RELOAD;
                    end else if (timer != '0) begin
                        timer <= timer - TIMER_ONE;
                    end else if (bus.door_closed) begin
                        state    <= LOCKED;
                        relay_on <= 1'b0;
                    end else begin
                        state    <= WAIT_CLOSE;
                        relay_on <= 1'b0;
                        alarm    <= 1'b1;
                    end
                end

                WAIT_CLOSE: begin
                    if (bus.unlock_pulse) begin
                        state      <= OPEN;
                        timer      <= OPEN_RELOAD;
                        fail_count <= 4'd0;
                        relay_on   <= 1'b1;
                        alarm      <= 1'b0;
                    end else if (bus.door_closed) begin
                        state <= LOCKED;
                        alarm <= 1'b0;
                    end
                end

                LOCKOUT: begin
                    if (timer == '0) begin
                        state      <= LOCKED;
                        fail_count <= 4'd0;
                        lockout    <= 1'b0;
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end

                default: begin
                    state      <= LOCKED;
                    timer      <= '0;
                    fail_count <= 4'd0;
                    relay_on   <= 1'b0;
                    alarm      <= 1'b0;
                    lockout    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_door_access_ctrl.sv
// Self-checking bench for door_access_ctrl: directed vector table, hand-written
// multi-cycle sequences, then random stimulus against a remaining-cycles model.
module tb_door_access_ctrl;

    localparam int OPEN_C = 4;
    localparam int MAXF   = 3;
    localparam int LOCK_C = 6;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    door_access_ctrl_if bus ();

    door_access_ctrl #(
        .OPEN_CYCLES   (OPEN_C),
        .MAX_FAILS     (MAXF),
        .LOCKOUT_CYCLES(LOCK_C),
        .CNT_W         (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic       u;
        logic       a;
        logic       d;
        logic       relay;
        logic       alarm;
        logic       lock;
        logic [3:0] fc;
    } vec_t;

    vec_t vecs[$];

    // Model: remaining relay cycles, remaining lockout cycles, alarm flag, fail tally.
    int m_open;
    int m_lock;
    bit m_alarm;
    int m_fails;

    function automatic vec_t mk(logic u, logic a, logic d, logic r, logic al, logic lo, logic [3:0] fc);
        vec_t v;
        v.u = u; v.a = a; v.d = d; v.relay = r; v.alarm = al; v.lock = lo; v.fc = fc;
        return v;
    endfunction

    task automatic modelReset();
        m_open  = 0;
        m_lock  = 0;
        m_alarm = 0;
        m_fails = 0;
    endtask

    task automatic modelStep(input logic u, input logic a, input logic d);
        if (m_lock > 0) begin
            m_lock = m_lock - 1;
            if (m_lock == 0) m_fails = 0;
        end else if (u) begin
            m_open  = OPEN_C;
            m_alarm = 0;
            m_fails = 0;
        end else if (m_open > 0) begin
            m_open = m_open - 1;
            if (m_open == 0 && !d) m_alarm = 1;
        end else if (m_alarm) begin
            if (d) m_alarm = 0;
        end else if (a) begin
            if (m_fails < MAXF) m_fails = m_fails + 1;
            if (m_fails == MAXF) m_lock = LOCK_C;
        end
    endtask

    task automatic applyStimulus(input logic u, input logic a, input logic d);
        @(negedge clk);
        bus.unlock_pulse = u;
        bus.attempt_end  = a;
        bus.door_closed  = d;
        @(posedge clk);
        #1;
        bus.unlock_pulse = 1'b0;
        bus.attempt_end  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic r, input logic al,
                               input logic lo, input logic [3:0] fc);
        checks++;
        if (bus.relay_on !== r || bus.alarm !== al || bus.lockout !== lo || bus.fail_count !== fc) begin
            errors++;
            $display("[TB] FAIL %s: got relay=%0b alarm=%0b lockout=%0b fail=%0d, expected relay=%0b alarm=%0b lockout=%0b fail=%0d",
                     name, bus.relay_on, bus.alarm, bus.lockout, bus.fail_count, r, al, lo, fc);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.unlock_pulse = 1'b0;
        bus.attempt_end  = 1'b0;
        bus.door_closed  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        reset = 1'b0;

        // Lockout entry and exit, ignored unlock, success-wins tie, extension and alarm.
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 4'd1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 4'd2));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 4'd3));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 4'd3));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 1, 0, 0, 1, 4'd3));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 4'd1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 4'd2));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 4'd0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 4'd0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 1, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4'd0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 4'd0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 4'd0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 4'd0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 1, 1, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4'd0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].u, vecs[i].a, vecs[i].d);
            checkOutput($sformatf("vec%0d", i), vecs[i].relay, vecs[i].alarm, vecs[i].lock, vecs[i].fc);
        end

        // Open window length with door closed at expiry.
        doReset();
        repeat (9) applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 1);
        for (int i = 0; i < OPEN_C; i++) begin
            checkOutput($sformatf("window_c%0d", i), 1'b1, 1'b0, 1'b0, 4'd0);
            applyStimulus(0, 0, 1);
        end
        checkOutput("window_closed", 1'b0, 1'b0, 1'b0, 4'd0);

        // Asynchronous reset mid-lockout, then a fresh unlock.
        repeat (3) applyStimulus(0, 1, 1);
        applyStimulus(0, 0, 1);
        checkOutput("pre_reset_lockout", 1'b0, 1'b0, 1'b1, 4'd3);
        #2 reset = 1'b1;
        #1 checkOutput("async_reset_lockout", 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        applyStimulus(1, 0, 1);
        checkOutput("unlock_after_reset", 1'b1, 1'b0, 1'b0, 4'd0);

        // Asynchronous reset mid-open.
        applyStimulus(0, 0, 1);
        #2 reset = 1'b1;
        #1 checkOutput("async_reset_open", 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        applyStimulus(1, 0, 0);
        checkOutput("unlock_after_reset2", 1'b1, 1'b0, 1'b0, 4'd0);

        // Random traffic against the model.
        doReset();
        modelReset();
        bus.door_closed = 1'b1;
        for (int i = 0; i < 800; i++) begin
            logic u, a, d;
            u = ($urandom_range(0, 11) == 0);
            a = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 9) == 0) ? ~bus.door_closed : bus.door_closed;
            applyStimulus(u, a, d);
            modelStep(u, a, d);
            checkOutput($sformatf("rand%0d", i), m_open > 0, m_alarm, m_lock > 0, 4'(m_fails));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
